// File: rtl/btn_pkg.sv
// btn_pkg: shared debounce FSM state type and board default timing
package btn_pkg;

    typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} btn_state_t;

    localparam int DEBOUNCE_CYCLES_50MHZ_10MS = 500000;

endpackage

// File: rtl/btn_step_conditioner_sync_chain.sv
// sync_chain: multi-flop synchronizer for an asynchronous input with a chosen reset value
module sync_chain #(
    parameter int STAGES  = 2,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    // shift the raw pin through the chain; reset parks it at the idle pin level
    always_ff @(posedge clk) begin
        if (reset) r_sync <= {STAGES{RST_VAL}};
        else       r_sync <= {r_sync[STAGES-2:0], d};
    end

    assign q = r_sync[STAGES-1];

endmodule

// File: rtl/btn_step_conditioner.sv
// btn_step_conditioner: synchronize, debounce and pulse-convert a raw push button
module btn_step_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ_10MS,
    parameter int SYNC_STAGES     = 2,
    parameter bit BTN_ACTIVE_LOW  = 1'b1,
    parameter int CNT_W           = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_raw,
    output logic             btn_level,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic [CNT_W-1:0] press_count,
    output logic             busy
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be >= 2");
    end

    logic             w_sync;
    logic             w_pressed;
    btn_state_t       r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_press_pend;
    logic             r_rel_pend;
    logic             r_btn_level;
    logic             r_press_pulse;
    logic             r_release_pulse;
    logic [CNT_W-1:0] r_press_count;
    logic             r_busy;

    sync_chain #(
        .STAGES (SYNC_STAGES),
        .RST_VAL(BTN_ACTIVE_LOW)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (btn_raw),
        .q    (w_sync)
    );

    assign w_pressed = w_sync ^ BTN_ACTIVE_LOW;

    // debounce FSM; accepted edges raise a pending flag that the output registers turn into pulses next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= RELEASED;
            r_cnt           <= '0;
            r_press_pend    <= 1'b0;
            r_rel_pend      <= 1'b0;
            r_btn_level     <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_press_count   <= '0;
            r_busy          <= 1'b0;
        end else begin
            r_press_pend    <= 1'b0;
            r_rel_pend      <= 1'b0;
            r_busy          <= (r_state == PRESS_WAIT) || (r_state == RELEASE_WAIT);
            r_press_pulse   <= r_press_pend;
            r_release_pulse <= r_rel_pend;
            if (r_press_pend) begin
                r_btn_level   <= 1'b1;
                r_press_count <= r_press_count + 1'b1;
            end else if (r_rel_pend) begin
                r_btn_level <= 1'b0;
            end
            case (r_state)
                RELEASED: begin
                    if (w_pressed) begin
                        r_state <= PRESS_WAIT;
                        r_cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!w_pressed) begin
                        r_state <= RELEASED;
                        r_cnt   <= '0;
                    end else if (r_cnt == CMAX) begin
                        r_state      <= PRESSED;
                        r_press_pend <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!w_pressed) begin
                        r_state <= RELEASE_WAIT;
                        r_cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (w_pressed) begin
                        r_state <= PRESSED;
                    end else if (r_cnt == CMAX) begin
                        r_state    <= RELEASED;
                        r_rel_pend <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= RELEASED;
            endcase
        end
    end

    assign btn_level     = r_btn_level;
    assign press_pulse   = r_press_pulse;
    assign release_pulse = r_release_pulse;
    assign press_count   = r_press_count;
    assign busy          = r_busy;

endmodule
